// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin stream arbiter driving the select of a 2:1 datapath mux.
// A grant is held for up to BURST_LEN accepted beats so bursts are never interleaved.
module mux_sel_arbiter #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    output logic a_ready,
    input  logic b_valid,
    output logic b_ready,
    output logic sel,
    output logic m_valid,
    input  logic m_ready,
    output logic busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_A = 2'd1;
    localparam logic [1:0] SERVE_B = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             busy_q;
    logic             last_b_q, last_b_d;  // 1: B was served most recently

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        last_b_d = last_b_q;
        m_valid  = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the source opposite the last-served marker wins.
                if (a_valid && (!b_valid || last_b_q)) begin
                    state_d = SERVE_A;
                    sel_d   = 1'b0;
                end else if (b_valid) begin
                    state_d = SERVE_B;
                    sel_d   = 1'b1;
                end
            end

            SERVE_A: begin
                m_valid = a_valid;
                a_ready = m_ready;
                if (!a_valid) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    last_b_d = 1'b0;
                end else if (m_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d    = '0;
                        last_b_d = 1'b0;
                        if (b_valid) begin
                            state_d = SERVE_B;
                            sel_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            SERVE_B: begin
                m_valid = b_valid;
                b_ready = m_ready;
                if (!b_valid) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    last_b_d = 1'b1;
                end else if (m_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d    = '0;
                        last_b_d = 1'b1;
                        if (a_valid) begin
                            state_d = SERVE_A;
                            sel_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            busy_q   <= (state_d != IDLE);
            last_b_q <= last_b_d;
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: burst-length 4 and burst-length 1 instances share stimulus and are
// compared every cycle against a grant/beats-left model, plus directed literal expectations.
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst, av, bv, mr;
    logic ar0, br0, sel0, mv0, bz0;
    logic ar1, br1, sel1, mv1, bz1;

    int checks = 0;
    int errors = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    mux_sel_arbiter #(.BURST_LEN(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .a_valid(av), .a_ready(ar0), .b_valid(bv), .b_ready(br0),
        .sel(sel0), .m_valid(mv0), .m_ready(mr), .busy(bz0)
    );

    mux_sel_arbiter #(.BURST_LEN(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .a_valid(av), .a_ready(ar1), .b_valid(bv), .b_ready(br1),
        .sel(sel1), .m_valid(mv1), .m_ready(mr), .busy(bz1)
    );

    // owner: -1 none, 0 A, 1 B; left: beats remaining in the current grant
    typedef struct {
        int owner;
        int left;
        int last;
        int sel;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mreset();
        mdl_t r;
        r.owner = -1;
        r.left  = 0;
        r.last  = 1;
        r.sel   = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int blen, bit a, bit b, bit r);
        mdl_t n = m;
        bit mine, other;
        if (m.owner < 0) begin
            if (a || b) begin
                if (a && b) n.owner = 1 - m.last;
                else        n.owner = a ? 0 : 1;
                n.left = blen;
                n.sel  = n.owner;
            end
        end else begin
            mine  = (m.owner == 1) ? b : a;
            other = (m.owner == 1) ? a : b;
            if (!mine) begin
                n.last  = m.owner;
                n.owner = -1;
                n.left  = 0;
            end else if (r) begin
                n.left = m.left - 1;
                if (n.left == 0) begin
                    n.last = m.owner;
                    n.left = blen;
                    if (other) begin
                        n.owner = 1 - m.owner;
                        n.sel   = n.owner;
                    end
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mdl_t m, input logic ar, input logic br,
                       input logic s, input logic mv, input logic bz);
        logic emv;
        emv = (m.owner == 0) ? av : (m.owner == 1) ? bv : 1'b0;
        chk({tag, " m_valid"}, 32'(mv), 32'(emv));
        chk({tag, " a_ready"}, 32'(ar), 32'((m.owner == 0) && mr));
        chk({tag, " b_ready"}, 32'(br), 32'((m.owner == 1) && mr));
        chk({tag, " sel"}, 32'(s), 32'(m.sel));
        chk({tag, " busy"}, 32'(bz), 32'(m.owner >= 0));
    endtask

    task automatic chk_seq(input string name, input int exp[$], input int got[$]);
        chk({name, " length"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s beat %0d", name, i), 32'(got[i]), 32'(exp[i]));
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= mreset();
            m1 <= mreset();
        end else begin
            m0 <= mstep(m0, 4, av, bv, mr);
            m1 <= mstep(m1, 1, av, bv, mr);
        end
    end

    // Model comparison and datapath logging (a=8, b=16) on every falling edge.
    always @(negedge clk) begin
        cmp("bl4", m0, ar0, br0, sel0, mv0, bz0);
        cmp("bl1", m1, ar1, br1, sel1, mv1, bz1);
        if (mv0 && mr) q0.push_back(sel0 ? 16 : 8);
        if (mv1 && mr) q1.push_back(sel1 ? 16 : 8);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int  e[$];
        logic s;
        rst = 1'b1;
        av  = 1'b0;
        bv  = 1'b0;
        mr  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset sel", 32'(sel0), 0);
        chk("reset busy", 32'(bz0), 0);
        chk("reset m_valid", 32'(mv0), 0);
        chk("reset a_ready", 32'(ar0), 0);
        chk("reset b_ready", 32'(br0), 0);
        tick();
        rst = 1'b0;

        // Only A valid: one arbitration cycle, then 6 beats with no bubble between bursts.
        av = 1'b1;
        mr = 1'b1;
        q0.delete();
        @(negedge clk);
        chk("t1 arbitration m_valid", 32'(mv0), 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1 m_valid", 32'(mv0), 1);
            chk("t1 busy", 32'(bz0), 1);
            chk("t1 sel", 32'(sel0), 0);
            tick();
        end
        chk("t1 beats", 32'(q0.size()), 6);
        av = 1'b0;
        tick();
        @(negedge clk);
        chk("t1 idle busy", 32'(bz0), 0);

        // Both valid: bursts of four alternate; burst-length 1 alternates every beat.
        pulse_reset();
        av = 1'b1;
        bv = 1'b1;
        mr = 1'b1;
        tick();
        q0.delete();
        q1.delete();
        repeat (16) tick();
        e = '{8, 8, 8, 8, 16, 16, 16, 16, 8, 8, 8, 8, 16, 16, 16, 16};
        chk_seq("t2 burst4", e, q0);
        e = '{8, 16, 8, 16, 8, 16, 8, 16, 8, 16, 8, 16, 8, 16, 8, 16};
        chk_seq("t5 burst1", e, q1);

        // Both valid with m_ready toggling.
        pulse_reset();
        tick();
        q0.delete();
        for (int i = 0; i < 20; i++) begin
            mr = (i % 2 == 0);
            @(negedge clk);
            s = sel0;
            if (!mr) chk("t3 a_ready stalled", 32'(ar0), 0);
            tick();
            if (!mr) chk("t3 sel hold", 32'(sel0), 32'(s));
        end
        e = '{8, 8, 8, 8, 16, 16, 16, 16, 8, 8};
        chk_seq("t3 toggled ready", e, q0);

        // A drops after two beats while B waits.
        pulse_reset();
        mr = 1'b1;
        q0.delete();
        tick();
        tick();
        tick();
        av = 1'b0;
        @(negedge clk);
        chk("t4 drop m_valid", 32'(mv0), 0);
        tick();
        @(negedge clk);
        chk("t4 idle busy", 32'(bz0), 0);
        tick();
        av = 1'b1;
        @(negedge clk);
        chk("t4 serve_b busy", 32'(bz0), 1);
        chk("t4 serve_b sel", 32'(sel0), 1);
        repeat (6) tick();
        e = '{8, 8, 16, 16, 16, 16, 8, 8};
        chk_seq("t4 sequence", e, q0);

        // Reset in the middle of a B burst.
        pulse_reset();
        av = 1'b0;
        bv = 1'b1;
        tick();
        tick();
        tick();
        chk("t6 b burst sel", 32'(sel0), 1);
        #2;
        rst = 1'b1;
        av  = 1'b1;
        #1;
        chk("t6 async sel", 32'(sel0), 0);
        chk("t6 async m_valid", 32'(mv0), 0);
        chk("t6 async busy", 32'(bz0), 0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("t6 tie grant sel", 32'(sel0), 0);
        chk("t6 tie grant m_valid", 32'(mv0), 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Two-source round-robin stream arbiter that generates the select for the downstream 8-bit mux_2to1 datapath.
- Source A maps to sel=0 and source B maps to sel=1.
- Uses a valid/ready handshake on each source and on the merged output.
- Holds a grant for up to BURST_LEN accepted beats, so bursts from one source are not interleaved at the mux output.

Parameters:
- BURST_LEN, 4: maximum beats accepted per grant; legal range 1..255.
- CNT_W, 8: width of the beat counter; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  source A has a beat on mux input a.
- a_ready  output  1  beat on A accepted this cycle (when a_valid=1).
- b_valid  input  1  source B has a beat on mux input b.
- b_ready  output  1  beat on B accepted this cycle (when b_valid=1).
- sel  output  1  mux select; 0 = A, 1 = B. Registered.
- m_valid  output  1  mux output y holds a valid beat.
- m_ready  input  1  downstream accepts y.
- busy  output  1  a grant is active (state is not IDLE). Registered.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, sel=0, busy=0, beat counter=0.
  - last-served marker=B, so A wins the first tie.
  - a_ready=0, b_ready=0, m_valid=0.
- States: IDLE, SERVE_A, SERVE_B. State, sel, busy, counter and last-served are registers. m_valid, a_ready and b_ready are combinational from state, the valids and m_ready.
- IDLE:
  - m_valid=0, a_ready=0, b_ready=0; sel holds its last value.
  - Only a_valid=1: next state SERVE_A, sel<=0.
  - Only b_valid=1: next state SERVE_B, sel<=1.
  - Both valid: grant the source opposite the last-served marker.
  - Neither valid: stay in IDLE.
  - Arbitration latency: exactly one cycle from valid seen in IDLE to m_valid possible.
- SERVE_A:
  - m_valid=a_valid, a_ready=m_ready, b_ready=0. A handshake is a_valid & m_ready.
  - On each handshake, counter increments.
  - On the handshake with counter==BURST_LEN-1: counter<=0, last-served<=A, then re-arbitrate in the same edge with no bubble:
    - if b_valid: go to SERVE_B, sel<=1;
    - else if a_valid: stay in SERVE_A with a fresh burst;
    - else go to IDLE.
  - a_valid=0 in SERVE_A (early burst end): go to IDLE, counter<=0, last-served<=A.
- SERVE_B: mirror of SERVE_A with roles of A and B swapped.
- Backpressure: m_ready=0 leaves the state, counter and sel unchanged. No beat is lost or duplicated.
- sel changes only on a state transition into SERVE_A or SERVE_B. It never changes while m_valid=1 and m_ready=0.
- The ready of the non-granted source is always 0.
- BURST_LEN=1: every accepted beat re-arbitrates, giving strict alternation when both sources are valid.
- Reset asserted mid-burst: the burst is aborted, and the next grant after release goes to A on a tie.

Test Plan (BURST_LEN=4 unless noted):
- After reset, a_valid=1, b_valid=0, m_ready=1 held for 6 cycles:
  - m_valid rises 1 cycle after a_valid; sel=0.
  - 6 beats are accepted; busy stays 1 with no bubble between bursts.
- a_valid=b_valid=1 continuously, m_ready=1, data a=8, b=16:
  - output y sequence is 8,8,8,8,16,16,16,16,8,…
  - sel toggles every 4 beats, and there is no idle cycle at switches.
- Same stimulus with m_ready toggled 1,0,1,0:
  - exactly 4 A beats are accepted before sel=1.
  - sel is stable during every m_ready=0 cycle, and a_ready=0 on those cycles.
- a_valid drops after 2 accepted beats while b_valid=1:
  - the next cycle is IDLE, then SERVE_B with sel=1.
  - A then wins the next tie.
- BURST_LEN=1, both sources valid, m_ready=1: sel alternates 0,1,0,1 on every beat.
- rst pulsed after 2 beats of a B burst:
  - outputs immediately go to sel=0, m_valid=0, busy=0.
  - after release with both sources valid, A is granted first.
